// File: rtl/lcd_text_ctrl_pkg.sv
// ============================================================================
// Module : lcd_text_ctrl_pkg
// Brief  : Shared HD44780 command constants, FSM states and init ROM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lcd_text_ctrl_pkg;

  localparam int CNT_W    = 21;
  localparam int RS_BIT   = 8;
  localparam int INIT_LEN = 6;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] SET_DDRAM     = 8'h80;
  localparam logic [7:0] LINE1_BASE    = 8'h40;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_SEND = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_IDLE      = 3'd3,
    ST_CHAR_SEND = 3'd4,
`ifdef LCD_AUTOWRAP_EN
    ST_ADDR_SEND = 3'd5,
`endif
    ST_CLR_SEND  = 3'd6,
    ST_CLR_WAIT  = 3'd7
  } state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return FUNC_SET_8B2L;
      3'd3:             return DISP_ON;
      3'd4:             return CLEAR;
      3'd5:             return ENTRY_INC;
      default:          return 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_delay_cnt.sv
// ============================================================================
// Module : lcd_delay_cnt
// Brief  : Loadable down-counter that stops at zero; zero_o flags expiry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lcd_delay_cnt #(
  parameter int              WIDTH   = 21,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_text_ctrl.sv
// ============================================================================
// Module : lcd_text_ctrl
// Brief  : HD44780 init sequencer and character/clear front-end for lcd_drv.
//          Define LCD_AUTOWRAP_EN to enable automatic line wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lcd_text_ctrl #(
  parameter int PWRUP_CYC = 1_500_000,
  parameter int GAP1_CYC  = 410_000,
  parameter int CLR_CYC   = 164_000,
  parameter int COLS      = 16,
  parameter int LINES     = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  input  logic       clr_i,
  output logic       init_done_o,
  output logic [8:0] data_o,
  output logic       data_valid_o,
  input  logic       device_ready_i
);

  import lcd_text_ctrl_pkg::*;

  localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  // Counter exits in the cycle it reads zero, so load N-1 for an N-cycle wait.
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP1_LD  = CNT_W'(GAP1_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);

  generate
    if (LINES < 1 || LINES > 2) begin : g_bad_lines
      $error("lcd_text_ctrl: LINES must be 1 or 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [8:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [2:0]       idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_q, row_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             xfer;
  logic             char_take;

  lcd_delay_cnt #(
    .WIDTH   (CNT_W),
    .RST_VAL (PWRUP_LD)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .zero_o  (cnt_zero)
  );

  assign xfer         = valid_q & device_ready_i;
  assign char_ready_o = (state_q == ST_IDLE) & done_q & ~clr_i;
  assign char_take    = char_ready_o & char_valid_i;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    col_d     = col_q;
    row_d     = row_q;
    done_d    = done_q;
    cnt_load  = 1'b0;
    cnt_value = GAP1_LD;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_d = ST_INIT_SEND;
          idx_d   = 3'd0;
          data_d  = {1'b0, init_rom(3'd0)};
        end
      end
      ST_INIT_SEND: begin
        if (xfer) begin
          // Stage the next ROM word now so a gap-free word follows back-to-back.
          idx_d  = idx_q + 3'd1;
          data_d = {1'b0, init_rom(idx_q + 3'd1)};
          if (idx_q == 3'd0) begin
            state_d  = ST_INIT_WAIT;
            cnt_load = 1'b1;
          end else if (idx_q == 3'd4) begin
            state_d   = ST_INIT_WAIT;
            cnt_load  = 1'b1;
            cnt_value = CLR_LD;
          end else if (idx_q == 3'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_INIT_WAIT: begin
        if (cnt_zero) state_d = ST_INIT_SEND;
      end
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLR_SEND;
          data_d  = {1'b0, CLEAR};
        end else if (char_take) begin
          state_d = ST_CHAR_SEND;
          data_d  = {1'b1, char_i};
        end
      end
      ST_CHAR_SEND: begin
        if (xfer) begin
`ifdef LCD_AUTOWRAP_EN
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = (LINES > 1) ? ~row_q : 1'b0;
            state_d = ST_ADDR_SEND;
            data_d  = {1'b0, SET_DDRAM | (row_d ? LINE1_BASE : 8'h00)};
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_IDLE;
          end
`else
          if (col_q != COL_LAST) col_d = col_q + 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef LCD_AUTOWRAP_EN
      ST_ADDR_SEND: begin
        if (xfer) state_d = ST_IDLE;
      end
`endif
      ST_CLR_SEND: begin
        if (xfer) begin
          state_d   = ST_CLR_WAIT;
          cnt_load  = 1'b1;
          cnt_value = CLR_LD;
        end
      end
      ST_CLR_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = 1'b0;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    valid_d = (state_d == ST_INIT_SEND) || (state_d == ST_CHAR_SEND) ||
`ifdef LCD_AUTOWRAP_EN
              (state_d == ST_ADDR_SEND) ||
`endif
              (state_d == ST_CLR_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_PWRUP;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign init_done_o  = done_q;

endmodule

`default_nettype wire
